fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the RISC_YAVA core.
- Holds the program counter and drives the instruction memory read address. The memory's read data (combinational read, zero while memory reset) returns in the same cycle.
- Captures the fetched word and its PC into the IF/ID pipeline register for the decode stage.
- Handles decode stall, branch/jump redirect with flush, a one-cycle boot bubble, and a halt state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_INSTR, 32'h0010_0073, encoding that stops fetch (EBREAK).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  decode cannot accept; hold PC and IF/ID
- redirect_valid  in  1  branch/jump taken, from execute
- redirect_pc  in  32  redirect target
- imem_addr  out  32  instruction memory byte address; top level zero-extends to the memory address width
- imem_rd  in  32  instruction word for imem_addr, same cycle
- if_id_instr  out  32  captured instruction
- if_id_pc  out  32  PC of if_id_instr
- if_id_valid  out  1  IF/ID holds a live instruction
- halted  out  1  fetch stopped on HALT_INSTR
- fetch_misalign  out  1  one-cycle pulse: redirect_pc[1:0] was nonzero

Behaviour:
- State machine: BOOT, RUN, HALT. Priority each cycle: rst > redirect_valid > stall > normal.
- Reset (rst=1 at clk edge):
  - state <= BOOT, pc <= RESET_PC.
  - if_id_instr <= 0, if_id_pc <= 0, if_id_valid <= 0.
  - halted <= 0, fetch_misalign <= 0.
- imem_addr = pc, combinational from the PC register.
- BOOT:
  - Lasts exactly one cycle after rst deasserts, unless redirect_valid is high that cycle.
  - Nothing is captured; if_id_valid stays 0; pc unchanged.
  - Next state is RUN.
  - A redirect in BOOT applies the normal redirect rules and also moves to RUN.
- RUN, normal (no redirect, no stall):
  - if_id_instr <= imem_rd, if_id_pc <= pc, if_id_valid <= 1.
  - pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - Throughput: one instruction per cycle.
- RUN, stall=1 with no redirect:
  - pc and all IF/ID outputs hold.
  - imem_rd is ignored; it is re-read when the stall drops.
- Redirect (redirect_valid=1, any state; overrides stall):
  - pc <= {redirect_pc[31:2], 2'b00}.
  - if_id_valid <= 0 (flush); if_id_instr and if_id_pc hold.
  - State becomes RUN.
  - fetch_misalign <= (redirect_pc[1:0] != 0) for one cycle; otherwise fetch_misalign <= 0.
- Halt detection:
  - Applies in RUN when stall=0, redirect_valid=0 and imem_rd == HALT_INSTR.
  - The halt word is not forwarded: if_id_valid <= 0, pc holds at the halt address.
  - state <= HALT, halted <= 1.
- HALT:
  - pc and IF/ID hold, if_id_valid=0, halted=1.
  - Exits only through redirect (to RUN, halted <= 0) or rst.
- Reset asserted mid-stream: reset values apply at that edge regardless of stall or redirect. Any in-flight IF/ID content is discarded.
- Latency: a word at pc appears on if_id_instr one clock edge after pc is presented. A redirect target reaches IF/ID two edges after redirect_valid is sampled.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt (32) and perf_stall_cnt (32).
  - perf_fetch_cnt increments on every edge where if_id_valid is written to 1.
  - perf_stall_cnt increments on every edge in RUN with stall=1 and redirect_valid=0.
  - Both reset to 0 and wrap at 2^32.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, no stall, memory words 32'hF0100093 at byte address 0 and 32'hF0200113 at 4: BOOT cycle shows if_id_valid=0, imem_addr=0. Next edge: if_id_instr=32'hF0100093, if_id_pc=0, valid=1. Following edge: 32'hF0200113 with pc 4, imem_addr=8.
- stall=1 for 3 cycles while if_id_pc=4: imem_addr stays 8 and IF/ID stays 32'hF0200113/4 all 3 cycles. First edge after stall drops captures the word at 8.
- redirect_valid=1, redirect_pc=32'h40 while stall=1: next edge gives if_id_valid=0, imem_addr=32'h40. The edge after that gives if_id_pc=32'h40.
- redirect_pc=32'h43: imem_addr becomes 32'h40 and fetch_misalign is high for exactly one cycle.
- HALT_INSTR placed at byte address 32'h10: halted=1 and if_id_valid=0 after the fetch at 32'h10; imem_addr stays 32'h10. A later redirect to 0 clears halted and fetch resumes at 0.
- rst pulsed mid-run with pc=32'h20 (FETCH_PERF_CNT_EN defined): all outputs return to reset values, imem_addr=RESET_PC, perf counters read 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the RISC_YAVA core: PC register, IF/ID capture, stall/redirect/halt control.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fetch_misalign
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  fetch_state_e state;
  logic [31:0]  pc;

  logic run_active;
  logic is_halt_word;
  logic capture_en;
  logic stall_run;

  assign imem_addr = pc;

  // Redirect outranks everything but reset, so every RUN-state event is qualified by it.
  assign run_active   = (state == RUN) && !redirect_valid;
  assign is_halt_word = (imem_rd == HALT_INSTR);
  assign capture_en   = run_active && !stall && !is_halt_word;
  assign stall_run    = run_active && stall;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      if_id_instr    <= 32'h0;
      if_id_pc       <= 32'h0;
      if_id_valid    <= 1'b0;
      halted         <= 1'b0;
      fetch_misalign <= 1'b0;
    end else begin
      fetch_misalign <= 1'b0;
      if (redirect_valid) begin
        // Flush the IF/ID slot; the target word is fetched on the following edge.
        state          <= RUN;
        pc             <= {redirect_pc[31:2], 2'b00};
        if_id_valid    <= 1'b0;
        halted         <= 1'b0;
        fetch_misalign <= |redirect_pc[1:0];
      end else begin
        case (state)
          BOOT: begin
            state <= RUN;
          end
          RUN: begin
            if (!stall) begin
              if (is_halt_word) begin
                // The halt word is swallowed and the PC parks on it.
                state       <= HALT;
                halted      <= 1'b1;
                if_id_valid <= 1'b0;
              end else begin
                if_id_instr <= imem_rd;
                if_id_pc    <= pc;
                if_id_valid <= 1'b1;
                pc          <= pc + 32'd4;
              end
            end
          end
          HALT: begin
            state <= HALT;
          end
          default: begin
            state <= BOOT;
          end
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (capture_en) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall_run)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = capture_en ^ stall_run;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, boot bubble, stall, redirect, misalign, halt, wrap, mid-run reset.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic        fetch_misalign;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  localparam logic [31:0] HALT_WORD = 32'h0010_0073;

  logic [31:0] mem [64];
  int total;
  int bad;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fetch_misalign (fetch_misalign)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory, 64 words, address wraps modulo 256 bytes.
  always_comb imem_rd = mem[imem_addr[7:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_addr(input string name, input logic [31:0] exp);
    total++;
    if (imem_addr !== exp) begin
      bad++;
      $display("FAIL %s imem_addr got=%h exp=%h", name, imem_addr, exp);
    end
  endtask

  task automatic chk_ifid(input string name, input logic [31:0] exp_instr,
                          input logic [31:0] exp_pc, input logic exp_valid);
    total++;
    if (if_id_instr !== exp_instr || if_id_pc !== exp_pc || if_id_valid !== exp_valid) begin
      bad++;
      $display("FAIL %s if_id got=%h/%h/%b exp=%h/%h/%b", name,
               if_id_instr, if_id_pc, if_id_valid, exp_instr, exp_pc, exp_valid);
    end
  endtask

  task automatic chk_valid(input string name, input logic exp);
    total++;
    if (if_id_valid !== exp) begin
      bad++;
      $display("FAIL %s if_id_valid got=%b exp=%b", name, if_id_valid, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic exp_halted, input logic exp_mis);
    total++;
    if (halted !== exp_halted || fetch_misalign !== exp_mis) begin
      bad++;
      $display("FAIL %s halted/misalign got=%b/%b exp=%b/%b", name,
               halted, fetch_misalign, exp_halted, exp_mis);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick();
    tick();
    chk_addr("reset_addr", 32'h0);
    chk_ifid("reset_ifid", 32'h0, 32'h0, 1'b0);
    chk_flags("reset_flags", 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_valid("boot_bubble_valid", 1'b0);
    chk_addr("boot_bubble_addr", 32'h0);
    tick();
    chk_ifid("first_fetch", 32'hF010_0093, 32'h0, 1'b1);
    chk_addr("first_fetch_addr", 32'h4);
    tick();
    chk_ifid("second_fetch", 32'hF020_0113, 32'h4, 1'b1);
    chk_addr("second_fetch_addr", 32'h8);
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_addr("stall_addr", 32'h8);
      chk_ifid("stall_hold", 32'hF020_0113, 32'h4, 1'b1);
    end
    stall = 1'b0;
    tick();
    chk_ifid("stall_release", 32'h0030_0193, 32'h8, 1'b1);
    chk_addr("stall_release_addr", 32'hC);
  endtask

  task automatic test_redirect();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    chk_addr("redir_addr", 32'h40);
    chk_ifid("redir_flush", 32'h0030_0193, 32'h8, 1'b0);
    chk_flags("redir_aligned", 1'b0, 1'b0);
    stall = 1'b0; redirect_valid = 1'b0;
    tick();
    chk_ifid("redir_target", 32'h00A0_0513, 32'h40, 1'b1);
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    tick();
    chk_addr("mis_addr", 32'h40);
    chk_flags("mis_pulse", 1'b0, 1'b1);
    chk_valid("mis_flush", 1'b0);
    redirect_valid = 1'b0;
    tick();
    chk_flags("mis_clear", 1'b0, 1'b0);
    chk_ifid("mis_target", 32'h00A0_0513, 32'h40, 1'b1);
  endtask

  task automatic test_halt();
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    chk_ifid("pre_halt", 32'h0040_0213, 32'hC, 1'b1);
    chk_addr("pre_halt_addr", 32'h10);
    tick();
    chk_flags("halt_set", 1'b1, 1'b0);
    chk_ifid("halt_ifid", 32'h0040_0213, 32'hC, 1'b0);
    chk_addr("halt_addr", 32'h10);
    tick();
    tick();
    chk_flags("halt_stays", 1'b1, 1'b0);
    chk_addr("halt_addr_stays", 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    chk_flags("halt_exit", 1'b0, 1'b0);
    chk_addr("halt_exit_addr", 32'h0);
    redirect_valid = 1'b0;
    tick();
    chk_ifid("halt_resume", 32'hF010_0093, 32'h0, 1'b1);
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk_addr("wrap_top", 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    tick();
    chk_ifid("wrap_fetch", 32'h00B0_0593, 32'hFFFF_FFFC, 1'b1);
    chk_addr("wrap_zero", 32'h0);
  endtask

  task automatic test_boot_redirect();
    rst = 1'b1;
    tick();
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    chk_addr("boot_redir_addr", 32'h40);
    chk_valid("boot_redir_valid", 1'b0);
    redirect_valid = 1'b0;
    tick();
    chk_ifid("boot_redir_fetch", 32'h00A0_0513, 32'h40, 1'b1);
  endtask

  task automatic test_mid_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h18;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    chk_addr("midrst_pre_addr", 32'h20);
    chk_ifid("midrst_pre_ifid", 32'h0070_0393, 32'h1C, 1'b1);
    rst = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    chk_addr("midrst_addr", 32'h0);
    chk_ifid("midrst_ifid", 32'h0, 32'h0, 1'b0);
    chk_flags("midrst_flags", 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0) begin
      bad++;
      $display("FAIL midrst_perf got=%h/%h exp=0/0", perf_fetch_cnt, perf_stall_cnt);
    end
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    tick();
    tick();
    tick();
    stall = 1'b1;
    tick();
    stall = 1'b0;
    total++;
    if (perf_fetch_cnt !== 32'd2 || perf_stall_cnt !== 32'd1) begin
      bad++;
      $display("FAIL perf_count got=%0d/%0d exp=2/1", perf_fetch_cnt, perf_stall_cnt);
    end
`endif
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 + (i << 7);
    mem[0]  = 32'hF010_0093;
    mem[1]  = 32'hF020_0113;
    mem[2]  = 32'h0030_0193;
    mem[3]  = 32'h0040_0213;
    mem[4]  = HALT_WORD;
    mem[6]  = 32'h0060_0313;
    mem[7]  = 32'h0070_0393;
    mem[16] = 32'h00A0_0513;
    mem[63] = 32'h00B0_0593;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    test_reset();
    test_stall();
    test_redirect();
    test_misalign();
    test_halt();
    test_wrap();
    test_boot_redirect();
    test_mid_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
